// File: rtl/circ_queue_pkg.sv
// circ_queue_pkg: shared defaults and clog2 helper for the parametrised circular queue.
package circ_queue_pkg;
    localparam int DATA_W_DEF   = 8;
    localparam int DEPTH_DEF    = 16;
    localparam int AF_GAP_DEF   = 2;
    localparam int AE_LEVEL_DEF = 2;

    function automatic int clog2(input int v);
        for (int r = 0; r < 31; r++)
            if ((1 << r) >= v) return r;
        return 31;
    endfunction
endpackage

// File: rtl/circ_queue_mem.sv
// circ_queue_mem: queue storage, sync write, registered read; CIRC_QUEUE_PEEK_EN adds a combinational peek port.
module circ_queue_mem
    import circ_queue_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
`ifdef CIRC_QUEUE_PEEK_EN
    input  logic [AW-1:0]     peek_addr_i,
    output logic [DATA_W-1:0] peek_data_o,
`endif
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Read and write share an edge: a read of the slot being overwritten returns the old word.
    always_ff @(posedge clk)
        if (we_i) mem_q[waddr_i] <= wdata_i;

    always_ff @(posedge clk or negedge rst)
        if (!rst) rdata_o <= '0;
        else if (re_i) rdata_o <= mem_q[raddr_i];

`ifdef CIRC_QUEUE_PEEK_EN
    assign peek_data_o = mem_q[peek_addr_i];
`endif
endmodule

// File: rtl/circ_queue_param.sv
// circ_queue_param: circular queue controller (pointers, count, flags, sticky errors); CIRC_QUEUE_PEEK_EN enables peek.
module circ_queue_param
    import circ_queue_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AF_LEVEL = DEPTH - AF_GAP_DEF,
    parameter int AE_LEVEL = AE_LEVEL_DEF,
    localparam int AW      = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic [AW-1:0]     peek_off,
    output logic [DATA_W-1:0] peek_data,
    output logic              peek_valid,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_AF   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] CNT_AE   = (AW+1)'(AE_LEVEL);

    logic [AW-1:0] head_q, tail_q;
    logic [AW:0]   count_q, count_d;
    logic          rd_valid_q, ovf_q, ovf_d, udf_q, udf_d;
    logic          push_ok, pop_ok;

    assign full         = count_q == CNT_FULL;
    assign empty        = count_q == '0;
    assign almost_full  = count_q >= CNT_AF;
    assign almost_empty = count_q <= CNT_AE;
    assign count        = count_q;
    assign rd_valid     = rd_valid_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

    // A pop frees the head slot in the same edge, so a full queue may still take a push.
    assign pop_ok  = en & rd & ~empty;
    assign push_ok = en & wr & (~full | pop_ok);

    always_comb begin
        count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        ovf_d   = (ovf_q & ~clr_err) | (en & wr & ~push_ok);
        udf_d   = (udf_q & ~clr_err) | (en & rd & empty);
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            head_q     <= pop_ok  ? head_q + 1'b1 : head_q;
            tail_q     <= push_ok ? tail_q + 1'b1 : tail_q;
            count_q    <= count_d;
            rd_valid_q <= pop_ok;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end

`ifdef CIRC_QUEUE_PEEK_EN
    assign peek_valid = {1'b0, peek_off} < count_q;
`else
    logic unused_peek;
    assign unused_peek = &{1'b0, peek_off};
    assign peek_valid  = 1'b0;
    assign peek_data   = '0;
`endif

    circ_queue_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .clk        (clk),
        .rst        (rst),
        .we_i       (push_ok),
        .waddr_i    (tail_q),
        .wdata_i    (wr_data),
        .re_i       (pop_ok),
        .raddr_i    (head_q),
`ifdef CIRC_QUEUE_PEEK_EN
        .peek_addr_i(head_q + peek_off),
        .peek_data_o(peek_data),
`endif
        .rdata_o    (rd_data)
    );
endmodule

// File: tb/tb_circ_queue_param.sv
// tb_circ_queue_param: scoreboard bench for circ_queue_param at DEPTH=16, DATA_W=8.
module tb_circ_queue_param;
    logic       clk = 1'b0, rst = 1'b0, en = 1'b1, wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
    logic [7:0] wr_data = '0;
    logic [3:0] peek_off = '0;
    logic [7:0] rd_data, peek_data;
    logic [4:0] count;
    logic       rd_valid, peek_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    int         checks = 0, errors = 0;
    logic [7:0] exp_q [$];

    circ_queue_param dut (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .wr_data(wr_data), .rd(rd),
        .rd_data(rd_data), .rd_valid(rd_valid), .peek_off(peek_off), .peek_data(peek_data),
        .peek_valid(peek_valid), .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .overflow(overflow),
        .underflow(underflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic cyc(input logic w, input logic [7:0] d, input logic r);
        wr = w; wr_data = d; rd = r;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        cyc(1'b1, d, 1'b0);
    endtask

    task automatic pop(input logic [7:0] e);
        exp_q.push_back(e);
        cyc(1'b0, 8'h00, 1'b1);
    endtask

    // Monitor: every presented word must match the oldest expected pop.
    initial forever begin
        @(negedge clk);
        if (rd_valid) begin
            if (exp_q.size() == 0) chk("unexpected_rd_valid", {24'h0, rd_data}, 32'hFFFF_FFFF);
            else chk("rd_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
        end
    end

    initial begin
        #3;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ae", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_errs", {overflow, underflow}, 0);
        chk("rst_peek_valid", peek_valid, 0);
        #9 rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            chk("fill_count", count, 32'(i + 1));
            chk("fill_af", almost_full, 32'(i + 1 >= 14));
            chk("fill_ae", almost_empty, 32'(i + 1 <= 2));
        end
        chk("fill_full", full, 1);
        push(8'h99);
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", count, 16);

        cyc(1'b1, 8'hAA, 1'b1);
        exp_q.push_back(8'h00);
        chk("full_pp_count", count, 16);
        for (int i = 1; i < 16; i++) pop(8'(i));
        pop(8'hAA);
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);
        cyc(1'b0, 8'h00, 1'b1);
        chk("udf_flag", underflow, 1);
        chk("udf_rd_valid", rd_valid, 0);
        chk("udf_rd_data_hold", rd_data, 8'hAA);

        clr_err = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        chk("clr_errs", {overflow, underflow}, 0);

        cyc(1'b1, 8'h55, 1'b1);
        chk("empty_pp_udf", underflow, 1);
        chk("empty_pp_count", count, 1);
        chk("empty_pp_rd_valid", rd_valid, 0);
        pop(8'h55);
        chk("empty_pp_drain", count, 0);

        en = 1'b0;
        clr_err = 1'b1;
        cyc(1'b0, 8'h00, 1'b0);
        chk("clr_with_en0", underflow, 0);
        for (int i = 0; i < 4; i++) cyc(1'(i), 8'hEE, 1'(~i));
        chk("en0_count", count, 0);
        chk("en0_errs", {overflow, underflow}, 0);
        en = 1'b1;

        for (int i = 0; i < 10; i++) push(8'h20 + 8'(i));
        for (int i = 0; i < 10; i++) pop(8'h20 + 8'(i));
        for (int i = 0; i < 12; i++) push(8'h30 + 8'(i));
        chk("wrap_count12", count, 12);
        for (int i = 0; i < 12; i++) pop(8'h30 + 8'(i));
        chk("wrap_count0", count, 0);
        chk("wrap_errs", {overflow, underflow}, 0);

        for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
        peek_off = 4'd3; #1;
`ifdef CIRC_QUEUE_PEEK_EN
        chk("peek3_data", peek_data, 8'h13);
        chk("peek3_valid", peek_valid, 1);
        peek_off = 4'd5; #1;
        chk("peek5_valid", peek_valid, 0);
        peek_off = 4'd0; #1;
        chk("peek0_data", peek_data, 8'h10);
`else
        chk("peek_off_data", peek_data, 0);
        chk("peek_off_valid", peek_valid, 0);
`endif
        wr = 1'b1; wr_data = 8'h15;
        #2 rst = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_flags", {empty, almost_empty, full, almost_full}, 4'b1100);
        chk("arst_rd", {rd_valid, rd_data}, 0);
        chk("arst_peek_valid", peek_valid, 0);
        #2 rst = 1'b1; wr = 1'b0;
        @(posedge clk); #1;
        push(8'h77);
        chk("post_rst_count", count, 1);
        pop(8'h77);
        repeat (2) @(posedge clk);
        #1 chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
